// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - direct-mapped branch target buffer with 2-bit direction counters
// and resolved-branch statistics
module branch_predictor #(
  parameter int INDEX_BITS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_if,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  input  logic [31:0] upd_target,
  input  logic        upd_pred_taken,
  output logic [31:0] branch_cnt,
  output logic [31:0] mispred_cnt
);
  localparam int ENTRIES = 1 << INDEX_BITS;
  localparam int TAG_W   = 30 - INDEX_BITS;

  logic [ENTRIES-1:0] valid_q;
  logic [TAG_W-1:0]   tag_q    [ENTRIES];
  logic [31:0]        target_q [ENTRIES];
  logic [1:0]         ctr_q    [ENTRIES];

  logic [INDEX_BITS-1:0] if_idx;
  logic [INDEX_BITS-1:0] upd_idx;
  logic [TAG_W-1:0]      if_tag;
  logic [TAG_W-1:0]      upd_tag;
  logic                  if_hit;
  logic                  upd_hit;
  logic                  upd_pc_unused;

  assign if_idx  = pc_if[INDEX_BITS+1:2];
  assign if_tag  = pc_if[31:INDEX_BITS+2];
  assign upd_idx = upd_pc[INDEX_BITS+1:2];
  assign upd_tag = upd_pc[31:INDEX_BITS+2];
  assign upd_pc_unused = ^upd_pc[1:0];

  // Prediction reads the registered table only; a same-cycle update is not bypassed.
  assign if_hit      = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
  assign upd_hit     = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
  assign pred_taken  = if_hit && ctr_q[if_idx][1];
  assign pred_target = pred_taken ? target_q[if_idx] : pc_if + 32'd4;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= 2'b01;
      end
      branch_cnt  <= '0;
      mispred_cnt <= '0;
    end else if (upd_valid) begin
      branch_cnt <= branch_cnt + 32'd1;
      if (upd_pred_taken != upd_taken) begin
        mispred_cnt <= mispred_cnt + 32'd1;
      end
      if (upd_hit) begin
        if (upd_taken) begin
          if (ctr_q[upd_idx] != 2'b11) begin
            ctr_q[upd_idx] <= ctr_q[upd_idx] + 2'd1;
          end
          target_q[upd_idx] <= upd_target;
        end else if (ctr_q[upd_idx] != 2'b00) begin
          ctr_q[upd_idx] <= ctr_q[upd_idx] - 2'd1;
        end
      end else if (upd_taken) begin
        // Only taken branches earn a slot; allocation starts weakly-taken.
        valid_q[upd_idx]  <= 1'b1;
        tag_q[upd_idx]    <= upd_tag;
        target_q[upd_idx] <= upd_target;
        ctr_q[upd_idx]    <= 2'b10;
      end
    end
  end
endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 The block SHALL use parameter INDEX_BITS, default 4, which sets the log2 of the table entry count (16 entries).
REQ-002 The block SHALL have clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 The block SHALL have pc_if, input, 32 bits: the fetch-stage PC being predicted.
REQ-005 The block SHALL have pred_taken, output, 1 bit: predicted direction for pc_if.
REQ-006 The block SHALL have pred_target, output, 32 bits: predicted next PC for pc_if.
REQ-007 The block SHALL have upd_valid, input, 1 bit: a resolved branch is presented this cycle.
REQ-008 The block SHALL have upd_pc, input, 32 bits: PC of the resolved branch.
REQ-009 The block SHALL have upd_taken, input, 1 bit: the resolved direction, taken from the branch comparator output.
REQ-010 The block SHALL have upd_target, input, 32 bits: the resolved taken-target address.
REQ-011 The block SHALL have upd_pred_taken, input, 1 bit: the direction that was predicted for this branch at fetch.
REQ-012 The block SHALL have branch_cnt, output, 32 bits: count of resolved branches.
REQ-013 The block SHALL have mispred_cnt, output, 32 bits: count of direction mispredictions.

Function
REQ-014 Each table entry SHALL hold four fields: valid (1 bit), tag (30-INDEX_BITS bits), target (32 bits), and ctr (2-bit saturating counter).
REQ-015 The index SHALL be pc[INDEX_BITS+1:2] and the tag SHALL be pc[31:INDEX_BITS+2]; pc[1:0] SHALL be ignored.
REQ-016 Prediction SHALL be a combinational read of the registered table with zero-cycle latency.
REQ-017 A hit SHALL require both valid and a tag match.
REQ-018 pred_taken SHALL equal hit & ctr[1].
REQ-019 pred_target SHALL be the entry target when pred_taken=1, and otherwise pc_if+4, with the sum wrapping modulo 2^32.
REQ-020 On an update hit with upd_taken=1, ctr SHALL increment and saturate at 11, and target SHALL be overwritten with upd_target.
REQ-021 On an update hit with upd_taken=0, ctr SHALL decrement and saturate at 00, and target SHALL be unchanged.
REQ-022 On an update miss with upd_taken=1, the entry SHALL be allocated or replaced with valid=1, the new tag, target=upd_target, and ctr=10.
REQ-023 On an update miss with upd_taken=0, the table SHALL be unchanged.
REQ-024 Counter states SHALL be 00 strongly-not-taken, 01 weakly-not-taken, 10 weakly-taken, and 11 strongly-taken.
REQ-025 When upd_valid=1, branch_cnt SHALL increment by 1 at the clock edge.
REQ-026 When upd_valid=1 and upd_pred_taken != upd_taken, mispred_cnt SHALL increment by 1 at the clock edge.
REQ-027 Both statistics counters SHALL wrap from 0xFFFFFFFF to 0.
REQ-028 When upd_valid=0, no table entry or counter SHALL change.
REQ-029 When an update and a prediction address the same index in the same cycle, the prediction SHALL reflect pre-update state, with no bypass; the new state SHALL be visible from the next cycle.
REQ-030 A single update port SHALL be provided, with at most one update per cycle.

Reset
REQ-031 While rst=1, all valid bits SHALL be 0, all ctr SHALL be 01, all tags and targets SHALL be 0, and branch_cnt and mispred_cnt SHALL be 0.
REQ-032 While rst=1, pred_taken SHALL be 0 and pred_target SHALL be pc_if+4.
REQ-033 Assertion of rst mid-operation SHALL clear all state immediately without waiting for clk, and an update coincident with rst SHALL be discarded.
REQ-034 The first update SHALL take effect on the first rising clk edge after rst deasserts.

Verification
REQ-035 The bench SHALL cover cold start: after rst, pc_if=0x00000100 -> pred_taken=0, pred_target=0x00000104, and both counters 0.
REQ-036 The bench SHALL cover allocate-then-predict: update upd_pc=0x100, upd_taken=1, upd_target=0x80, upd_pred_taken=0 -> next cycle pc_if=0x100 gives pred_taken=1 and pred_target=0x80; branch_cnt=1 and mispred_cnt=1.
REQ-037 The bench SHALL cover saturation: from a PC at ctr=10, apply three taken updates -> ctr=11, then one not-taken update -> ctr=10 and still predicted taken, then a second not-taken update -> ctr=01 and pred_taken=0 with pred_target=pc+4.
REQ-038 The bench SHALL cover an alias with tag mismatch: entry allocated at 0x100, then pc_if=0x140 (same index, different tag) -> pred_taken=0; a taken update at 0x140 with target 0x200 replaces the entry, so 0x100 then misses.
REQ-039 The bench SHALL cover same-cycle read/write: update 0x100 as taken while pc_if=0x100 on an invalid entry -> pred_taken=0 in that cycle and 1 in the next cycle.
REQ-040 The bench SHALL cover async reset mid-stream: assert rst between clk edges after 5 updates -> counters 0 and pred_taken=0 immediately, before the next edge.
